pwm_reg_ctrl: RTL

PWM_REG_CTRL -- requirements
Module: pwm_reg_ctrl

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_reg_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register controller: bus widths, register map,
// init sequencing and FSM state encoding.
package pwm_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;

   localparam logic [ADDR_W-1:0] ADDR_OUT_7_0  = ADDR_W'(7'h00);
   localparam logic [ADDR_W-1:0] ADDR_OUT_15_8 = ADDR_W'(7'h01);
   localparam logic [ADDR_W-1:0] ADDR_PWM_7_0  = ADDR_W'(7'h02);
   localparam logic [ADDR_W-1:0] ADDR_PWM_15_8 = ADDR_W'(7'h03);
   localparam logic [ADDR_W-1:0] ADDR_DUTY     = ADDR_W'(7'h04);

   // Init index of the last register in the default-load sequence
   localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(3'd4);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } pwm_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } pwm_wr_t;

endpackage

// File: rtl/pwm_reg_ctrl.sv
// PWM control register file: loads defaults after reset, applies output-enable
// writes immediately and stages PWM writes until the counter wraps.
module pwm_reg_ctrl
   import pwm_pkg::*;
#(
   parameter logic [DATA_W-1:0] DEF_OUT_7_0  = 8'h00,
   parameter logic [DATA_W-1:0] DEF_OUT_15_8 = 8'h00,
   parameter logic [DATA_W-1:0] DEF_PWM_7_0  = 8'h00,
   parameter logic [DATA_W-1:0] DEF_PWM_15_8 = 8'h00,
   parameter logic [DATA_W-1:0] DEF_DUTY     = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              period_end,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle,
   output logic              init_done,
   output logic              commit,
   output logic              err_addr
);

   pwm_state_e        state;
   logic [IDX_W-1:0]  init_idx;
   logic              dirty;
   logic [DATA_W-1:0] sh_pwm_7_0;
   logic [DATA_W-1:0] sh_pwm_15_8;
   logic [DATA_W-1:0] sh_duty;

   pwm_wr_t wr_req_c;
   logic    wr_fire_c;

   assign wr_req_c  = '{addr: wr_addr, data: wr_data};
   assign wr_fire_c = wr_valid && wr_ready && (state == S_RUN);

   // Controller FSM and register file; commit/err_addr are single-cycle pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_INIT;
         init_idx        <= '0;
         dirty           <= 1'b0;
         wr_ready        <= 1'b0;
         init_done       <= 1'b0;
         commit          <= 1'b0;
         err_addr        <= 1'b0;
         en_reg_out_7_0  <= DEF_OUT_7_0;
         en_reg_out_15_8 <= DEF_OUT_15_8;
         en_reg_pwm_7_0  <= DEF_PWM_7_0;
         en_reg_pwm_15_8 <= DEF_PWM_15_8;
         pwm_duty_cycle  <= DEF_DUTY;
         sh_pwm_7_0      <= DEF_PWM_7_0;
         sh_pwm_15_8     <= DEF_PWM_15_8;
         sh_duty         <= DEF_DUTY;
      end else begin
         commit   <= 1'b0;
         err_addr <= 1'b0;
         unique case (state)
            S_INIT: begin
               case (init_idx)
                  IDX_W'(3'd0): en_reg_out_7_0  <= DEF_OUT_7_0;
                  IDX_W'(3'd1): en_reg_out_15_8 <= DEF_OUT_15_8;
                  IDX_W'(3'd2): begin
                     en_reg_pwm_7_0 <= DEF_PWM_7_0;
                     sh_pwm_7_0     <= DEF_PWM_7_0;
                  end
                  IDX_W'(3'd3): begin
                     en_reg_pwm_15_8 <= DEF_PWM_15_8;
                     sh_pwm_15_8     <= DEF_PWM_15_8;
                  end
                  IDX_W'(3'd4): begin
                     pwm_duty_cycle <= DEF_DUTY;
                     sh_duty        <= DEF_DUTY;
                  end
                  default: ;
               endcase
               if (init_idx == INIT_LAST) begin
                  state     <= S_RUN;
                  init_idx  <= '0;
                  init_done <= 1'b1;
                  wr_ready  <= 1'b1;
               end else begin
                  init_idx <= init_idx + IDX_W'(1);
               end
            end
            S_RUN: begin
               // Commit sees the shadow values from before this edge, so a
               // coincident staged write lands after the copy and stays dirty.
               if (period_end && dirty) begin
                  en_reg_pwm_7_0  <= sh_pwm_7_0;
                  en_reg_pwm_15_8 <= sh_pwm_15_8;
                  pwm_duty_cycle  <= sh_duty;
                  dirty           <= 1'b0;
                  commit          <= 1'b1;
               end
               if (wr_fire_c) begin
                  case (wr_req_c.addr)
                     ADDR_OUT_7_0:  en_reg_out_7_0  <= wr_req_c.data;
                     ADDR_OUT_15_8: en_reg_out_15_8 <= wr_req_c.data;
                     ADDR_PWM_7_0: begin
                        sh_pwm_7_0 <= wr_req_c.data;
                        dirty      <= 1'b1;
                     end
                     ADDR_PWM_15_8: begin
                        sh_pwm_15_8 <= wr_req_c.data;
                        dirty       <= 1'b1;
                     end
                     ADDR_DUTY: begin
                        sh_duty <= wr_req_c.data;
                        dirty   <= 1'b1;
                     end
                     default: err_addr <= 1'b1;
                  endcase
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule
